tcam_rule_ctrl: RTL and testbench

- Initiator that sits in front of one tcam7x64 block (7-bit key, 64 rule IDs, one 32x256 dual-port SRAM behind it).
- Turns high-level requests (search key, write ternary rule, erase rule) into SRAM port sequences.
- Searches are a single read; the returned 64-bit match vector is the response.
- Writes and erases do a read-modify-write sweep over all 128 key rows.

---
 rtl/tcam_ctrl_pkg.sv | 36 +++
 rtl/tcam_prio_enc64.sv | 20 ++
 rtl/tcam_rule_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tcam_rule_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcam_ctrl_pkg.sv
// Shared types and constants for the tcam7x64 rule controller.
// Optional priority encoding of search results is enabled by TCAM_PRIO_ENC_EN.
package tcam_ctrl_pkg;

    localparam int KEY_W  = 7;
    localparam int ID_W   = 6;
    localparam int ROWS   = 128;
    localparam int HALF_W = 32;

    // Request opcodes; encoding 3 is reserved and handled as a search.
    typedef enum logic [1:0] {
        OP_SEARCH = 2'd0,
        OP_WRITE  = 2'd1,
        OP_ERASE  = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        W_RD   = 3'd3,
        W_WAIT = 3'd4,
        W_WR   = 3'd5,
        RSP    = 3'd6
    } state_e;

    // Value of one rule's bit in key row 'row': a ternary rule matches the
    // row when every cared-about bit agrees; erasing clears the bit everywhere.
    function automatic logic rule_bit(input logic [KEY_W-1:0] row,
                                      input logic [KEY_W-1:0] key,
                                      input logic [KEY_W-1:0] mask,
                                      input logic             erase);
        return erase ? 1'b0 : (((row ^ key) & ~mask) == '0);
    endfunction

endpackage

// File: rtl/tcam_prio_enc64.sv
// 64-bit combinational priority encoder: reports whether any bit is set and
// the index of the lowest set bit. Only used when TCAM_PRIO_ENC_EN is defined.
module tcam_prio_enc64 (
    input  logic [63:0] in_vec,
    output logic        hit,
    output logic [5:0]  idx
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        hit = |in_vec;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = 6'(i);
            end
        end
    end

endmodule

// File: rtl/tcam_rule_ctrl.sv
// Request front-end for one tcam7x64 block. Searches are a single SRAM read;
// rule writes and erases sweep all 128 key rows with read-modify-write.
// Define TCAM_PRIO_ENC_EN to register hit / lowest-index alongside the match
// vector; otherwise rsp_hit_o and rsp_idx_o are constant 0.
module tcam_rule_ctrl
    import tcam_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [6:0]  req_key_i,
    input  logic [6:0]  req_mask_i,
    input  logic [5:0]  req_id_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [1:0]  rsp_op_o,
    output logic [63:0] rsp_match_o,
    output logic        rsp_hit_o,
    output logic [5:0]  rsp_idx_o,
    output logic        tcam_csb_o,
    output logic        tcam_web_o,
    output logic [3:0]  tcam_wmask_o,
    output logic [7:0]  tcam_addr_o,
    output logic [31:0] tcam_wdata_o,
    input  logic [63:0] tcam_rdata_i
);

    // Last value of the read-latency counter before read data is valid.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_e             state;
    logic [1:0]         op_reg;
    logic [KEY_W-1:0]   key_reg;
    logic [KEY_W-1:0]   mask_reg;
    logic [ID_W-1:0]    id_reg;
    logic [KEY_W-1:0]   row_reg;
    logic [1:0]         wait_cnt;

    logic               req_is_sweep;
    logic               rd_done;
    logic               search_capture;
    logic               sweep_done;
    logic [HALF_W-1:0]  rd_half;
    logic               new_bit;
    logic [HALF_W-1:0]  merged;

    assign req_ready_o    = (state == IDLE);
    assign req_is_sweep   = (req_op_i == OP_WRITE) || (req_op_i == OP_ERASE);
    assign rd_done        = (wait_cnt == WAIT_LAST);
    assign search_capture = (state == S_WAIT) && rd_done;
    assign sweep_done     = (state == W_WR) && (row_reg == 7'(ROWS - 1));

    // Rebuild the selected half-word with only this rule's bit replaced.
    always_comb begin
        rd_half = id_reg[5] ? tcam_rdata_i[63:32] : tcam_rdata_i[31:0];
        new_bit = rule_bit(row_reg, key_reg, mask_reg, op_reg == OP_ERASE);
        merged  = rd_half;
        merged[id_reg[4:0]] = new_bit;
    end

    // Main sequencer: request capture, SRAM port sequencing and response hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            op_reg       <= '0;
            key_reg      <= '0;
            mask_reg     <= '0;
            id_reg       <= '0;
            row_reg      <= '0;
            wait_cnt     <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_op_o     <= '0;
            rsp_match_o  <= '0;
            tcam_csb_o   <= 1'b1;
            tcam_web_o   <= 1'b1;
            tcam_wmask_o <= '0;
            tcam_addr_o  <= '0;
            tcam_wdata_o <= '0;
        end else begin
            // The SRAM is deselected unless a state below issues an access.
            tcam_csb_o <= 1'b1;
            tcam_web_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op_reg     <= req_op_i;
                        key_reg    <= req_key_i;
                        mask_reg   <= req_mask_i;
                        id_reg     <= req_id_i;
                        rsp_op_o   <= req_op_i;
                        row_reg    <= '0;
                        tcam_csb_o <= 1'b0;
                        if (req_is_sweep) begin
                            tcam_addr_o <= 8'h00;
                            state       <= W_RD;
                        end else begin
                            tcam_addr_o <= {1'b0, req_key_i};
                            state       <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (search_capture) begin
                        rsp_match_o <= tcam_rdata_i;
                        rsp_valid_o <= 1'b1;
                        state       <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                W_RD: begin
                    wait_cnt <= '0;
                    state    <= W_WAIT;
                end
                W_WAIT: begin
                    if (rd_done) begin
                        tcam_csb_o   <= 1'b0;
                        tcam_web_o   <= 1'b0;
                        tcam_addr_o  <= {id_reg[5], row_reg};
                        tcam_wmask_o <= 4'b0001 << id_reg[4:3];
                        tcam_wdata_o <= merged;
                        state        <= W_WR;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                W_WR: begin
                    if (sweep_done) begin
                        rsp_match_o <= '0;
                        rsp_valid_o <= 1'b1;
                        state       <= RSP;
                    end else begin
                        row_reg     <= row_reg + 7'd1;
                        tcam_csb_o  <= 1'b0;
                        tcam_addr_o <= {1'b0, row_reg + 7'd1};
                        state       <= W_RD;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TCAM_PRIO_ENC_EN
    logic       enc_hit;
    logic [5:0] enc_idx;
    logic       hit_reg;
    logic [5:0] idx_reg;

    tcam_prio_enc64 u_prio_enc (
        .in_vec (tcam_rdata_i),
        .hit    (enc_hit),
        .idx    (enc_idx)
    );

    // Hit and index are captured on the same edge as the match vector.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_reg <= 1'b0;
            idx_reg <= '0;
        end else if (search_capture) begin
            hit_reg <= enc_hit;
            idx_reg <= enc_idx;
        end else if (sweep_done) begin
            hit_reg <= 1'b0;
            idx_reg <= '0;
        end
    end

    assign rsp_hit_o = hit_reg;
    assign rsp_idx_o = idx_reg;
`else
    assign rsp_hit_o = 1'b0;
    assign rsp_idx_o = '0;
`endif

endmodule

// File: tb/tb_tcam_rule_ctrl.sv
// Self-checking bench for tcam_rule_ctrl with a behavioural 256x32 SRAM model.
// Hit/index expectations follow TCAM_PRIO_ENC_EN.
module tb_tcam_rule_ctrl;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [6:0]  req_key = '0;
    logic [6:0]  req_mask = '0;
    logic [5:0]  req_id = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_op;
    logic [63:0] rsp_match;
    logic        rsp_hit;
    logic [5:0]  rsp_idx;
    logic        tcam_csb;
    logic        tcam_web;
    logic [3:0]  tcam_wmask;
    logic [7:0]  tcam_addr;
    logic [31:0] tcam_wdata;
    logic [63:0] tcam_rdata;

    always #5 clk = ~clk;

    tcam_rule_ctrl #(.RD_LAT(RD_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_key_i    (req_key),
        .req_mask_i   (req_mask),
        .req_id_i     (req_id),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_op_o     (rsp_op),
        .rsp_match_o  (rsp_match),
        .rsp_hit_o    (rsp_hit),
        .rsp_idx_o    (rsp_idx),
        .tcam_csb_o   (tcam_csb),
        .tcam_web_o   (tcam_web),
        .tcam_wmask_o (tcam_wmask),
        .tcam_addr_o  (tcam_addr),
        .tcam_wdata_o (tcam_wdata),
        .tcam_rdata_i (tcam_rdata)
    );

    // SRAM model: a read at {x,r} returns {upper row r, lower row r}.
    logic [31:0] mem [0:255];
    logic [63:0] rd_pipe [0:RD_LAT-1];

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = '0;
        for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;
    end

    always @(posedge clk) begin
        if (!tcam_csb) begin
            if (!tcam_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (tcam_wmask[b]) mem[tcam_addr][b*8 +: 8] <= tcam_wdata[b*8 +: 8];
                end
            end else begin
                rd_pipe[0] <= {mem[{1'b1, tcam_addr[6:0]}], mem[{1'b0, tcam_addr[6:0]}]};
            end
        end
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign tcam_rdata = rd_pipe[RD_LAT-1];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic exp_hit(input logic h);
`ifdef TCAM_PRIO_ENC_EN
        return h;
`else
        return 1'b0 & h;
`endif
    endfunction

    function automatic logic [5:0] exp_idx(input logic [5:0] i);
`ifdef TCAM_PRIO_ENC_EN
        return i;
`else
        return 6'd0 & i;
`endif
    endfunction

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  key;
        logic [6:0]  mask;
        logic [5:0]  id;
        logic [63:0] match;
        logic        hit;
        logic [5:0]  idx;
        logic [3:0]  wmask;
        logic        a7;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] match;
        logic        hit;
        logic [5:0]  idx;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Scoreboard side: compare each response at its handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            $display("rsp op=%0d match=%h hit=%0d idx=%0d", rsp_op, rsp_match, rsp_hit, rsp_idx);
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(1), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("rsp_op", 64'(rsp_op), 64'(mon_e.op));
                check("rsp_match", rsp_match, mon_e.match);
                check("rsp_hit", 64'(rsp_hit), 64'(mon_e.hit));
                check("rsp_idx", 64'(rsp_idx), 64'(mon_e.idx));
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.op    = v.op;
        e.match = v.match;
        e.hit   = exp_hit(v.hit);
        e.idx   = exp_idx(v.idx);
        sb.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        logic sweep;
        int   cyc, writes, badw;
        sweep  = (v.op == 2'd1) || (v.op == 2'd2);
        cyc    = 0;
        writes = 0;
        badw   = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = v.op;
        req_key   = v.key;
        req_mask  = v.mask;
        req_id    = v.id;
        push_exp(v);
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (!tcam_csb && !tcam_web) begin
                writes++;
                if (tcam_wmask !== v.wmask || tcam_addr[7] !== v.a7 ||
                    tcam_addr[6:0] !== 7'(writes - 1)) badw++;
            end
        end while (!rsp_valid && cyc < 2000);
        if (sweep) begin
            check("sweep_busy_cycles", 64'(cyc - 1), 64'(128 * (2 + RD_LAT)));
            check("sweep_writes", 64'(writes), 64'(128));
            check("sweep_bad_writes", 64'(badw), 64'(0));
        end else begin
            check("search_latency", 64'(cyc), 64'(2 + RD_LAT));
            check("search_no_writes", 64'(writes), 64'(0));
        end
        @(posedge clk);
    endtask

    vec_t vecs[11];

    initial begin
        logic [63:0] held_match;
        logic [9:0]  held_misc;
        logic        found;
        int          w;
        vec_t        v;

        vecs[0]  = '{2'd1, 7'h05, 7'h00, 6'd3,  64'h0,                   1'b0, 6'd0,  4'b0001, 1'b0};
        vecs[1]  = '{2'd0, 7'h05, 7'h00, 6'd0,  64'h8,                   1'b1, 6'd3,  4'b0000, 1'b0};
        vecs[2]  = '{2'd0, 7'h04, 7'h00, 6'd0,  64'h0,                   1'b0, 6'd0,  4'b0000, 1'b0};
        vecs[3]  = '{2'd1, 7'h00, 7'h7F, 6'd40, 64'h0,                   1'b0, 6'd0,  4'b0010, 1'b1};
        vecs[4]  = '{2'd0, 7'h05, 7'h00, 6'd0,  64'h0000_0100_0000_0008, 1'b1, 6'd3,  4'b0000, 1'b0};
        vecs[5]  = '{2'd0, 7'h55, 7'h00, 6'd0,  64'h0000_0100_0000_0000, 1'b1, 6'd40, 4'b0000, 1'b0};
        vecs[6]  = '{2'd2, 7'h00, 7'h00, 6'd3,  64'h0,                   1'b0, 6'd0,  4'b0001, 1'b0};
        vecs[7]  = '{2'd0, 7'h05, 7'h00, 6'd0,  64'h0000_0100_0000_0000, 1'b1, 6'd40, 4'b0000, 1'b0};
        vecs[8]  = '{2'd1, 7'h10, 7'h03, 6'd17, 64'h0,                   1'b0, 6'd0,  4'b0100, 1'b0};
        vecs[9]  = '{2'd0, 7'h12, 7'h00, 6'd0,  64'h0000_0100_0002_0000, 1'b1, 6'd17, 4'b0000, 1'b0};
        vecs[10] = '{2'd3, 7'h14, 7'h00, 6'd0,  64'h0000_0100_0000_0000, 1'b1, 6'd40, 4'b0000, 1'b0};

        // Reset values, then an idle stretch with no requests.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_csb", 64'(tcam_csb), 64'(1));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_match", rsp_match, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_csb", 64'(tcam_csb), 64'(1));
        end

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Response back-pressure with a second request waiting behind it.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        v = '{2'd0, 7'h05, 7'h00, 6'd0, 64'h0000_0100_0000_0000, 1'b1, 6'd40, 4'b0000, 1'b0};
        req_valid = 1'b1; req_op = v.op; req_key = v.key; req_mask = '0; req_id = '0;
        push_exp(v);
        @(posedge clk); #1;
        v = '{2'd0, 7'h12, 7'h00, 6'd0, 64'h0000_0100_0002_0000, 1'b1, 6'd17, 4'b0000, 1'b0};
        req_key = v.key;
        push_exp(v);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 20);
        check("hold_rsp_seen", 64'(rsp_valid), 64'(1));
        held_match = rsp_match;
        held_misc  = {rsp_op, rsp_hit, rsp_idx, rsp_valid};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_match_stable", rsp_match, held_match);
            check("hold_fields_stable", 64'({rsp_op, rsp_hit, rsp_idx, rsp_valid}), 64'(held_misc));
            check("hold_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        check("after_hs_req_ready", 64'(req_ready), 64'(1));
        check("after_hs_csb_idle", 64'(tcam_csb), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("second_req_read", 64'({tcam_csb, tcam_web, tcam_addr}), 64'({1'b0, 1'b1, 8'h12}));
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rsp_valid && w < 20);
        check("second_rsp_seen", 64'(rsp_valid), 64'(1));
        @(posedge clk);

        // Reset in the middle of a WRITE sweep, at the read of row 60.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'd1; req_key = 7'h00; req_mask = 7'h7F; req_id = 6'd63;
        @(posedge clk); #1;
        req_valid = 1'b0;
        found = 1'b0;
        w = 0;
        while (!found && w < 1000) begin
            @(negedge clk);
            w++;
            if (!tcam_csb && tcam_web && tcam_addr == 8'd60) found = 1'b1;
        end
        check("row60_reached", 64'(found), 64'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_csb", 64'(tcam_csb), 64'(1));
        check("mid_rst_web", 64'(tcam_web), 64'(1));
        check("mid_rst_wmask", 64'(tcam_wmask), 64'(0));
        check("mid_rst_addr", 64'(tcam_addr), 64'(0));
        check("mid_rst_wdata", 64'(tcam_wdata), 64'(0));
        check("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_op", 64'(rsp_op), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        v = '{2'd0, 7'h3B, 7'h00, 6'd0, 64'h8000_0100_0000_0000, 1'b1, 6'd40, 4'b0000, 1'b0};
        run_vec(v);
        v = '{2'd0, 7'h3C, 7'h00, 6'd0, 64'h0000_0100_0000_0000, 1'b1, 6'd40, 4'b0000, 1'b0};
        run_vec(v);
        for (int r = 0; r < 128; r++) begin
            check($sformatf("partial_row_%0d", r), 64'(mem[128 + r][31]), 64'(r < 60));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
